// File: rtl/aes_loopback_ctrl.sv
// rtl/aes_loopback_ctrl.sv - block FIFO feeding an external AES core with encrypt, decrypt and self-checking loopback modes
module aes_loopback_ctrl #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic [DATA_W-1:0]            keyin,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         core_start,
    output logic                         core_sel,
    output logic [DATA_W-1:0]            core_key,
    output logic [DATA_W-1:0]            core_data,
    input  logic                         core_done,
    input  logic [DATA_W-1:0]            core_result,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic                         mismatch,
    output logic [7:0]                   err_count,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START1,
        WAIT1,
        START2,
        WAIT2,
        OUT,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               rdy_q, rdy_d;
    logic               loop_q, loop_d;
    logic               dec_q, dec_d;
    logic [DATA_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0]  pt_q, pt_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic               mismatch_q, mismatch_d;
    logic [7:0]         err_q, err_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic push;
    logic pop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // rdy_q keeps in_ready low during reset and lets it rise on the first edge after release
    assign in_ready   = rdy_q && (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);

    assign fifo_count = count_q;
    assign core_key   = key_q;
    assign core_sel   = ((state_q == START2) || (state_q == WAIT2)) ? 1'b1 : dec_q;
    assign core_data  = (state_q == START2) ? res_q : pt_q;
    assign out_data   = res_q;
    assign mismatch   = mismatch_q;
    assign err_count  = err_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rdy_d      = 1'b1;
        loop_d     = loop_q;
        dec_d      = dec_q;
        key_d      = key_q;
        pt_d       = pt_q;
        res_d      = res_q;
        wait_d     = wait_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        core_start = 1'b0;
        out_valid  = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    pt_d    = mem_q[rd_ptr_q];
                    key_d   = keyin;
                    dec_d   = (mode == 2'b01);
                    loop_d  = mode[1];
                    state_d = START1;
                end
            end
            START1: begin
                core_start = 1'b1;
                wait_d     = '0;
                state_d    = WAIT1;
            end
            WAIT1: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = loop_q ? START2 : OUT;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = sat_inc(err_q);
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            START2: begin
                core_start = 1'b1;
                wait_d     = '0;
                state_d    = WAIT2;
            end
            WAIT2: begin
                if (core_done) begin
                    res_d = core_result;
                    if (core_result != pt_q) begin
                        mismatch_d = 1'b1;
                        err_d      = sat_inc(err_q);
                    end
                    state_d = OUT;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = sat_inc(err_q);
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b0;
            loop_q     <= 1'b0;
            dec_q      <= 1'b0;
            key_q      <= '0;
            pt_q       <= '0;
            res_q      <= '0;
            wait_q     <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            loop_q     <= loop_d;
            dec_q      <= dec_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            res_q      <= res_d;
            wait_q     <= wait_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_aes_loopback_ctrl.sv
// tb/tb_aes_loopback_ctrl.sv - randomized self-checking bench with an XOR core model and an output scoreboard
module tb_aes_loopback_ctrl;

    localparam int DATA_W  = 128;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              rst;
    logic [1:0]        mode;
    logic [DATA_W-1:0] keyin;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              core_start;
    logic              core_sel;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_data;
    logic              core_done;
    logic [DATA_W-1:0] core_result;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              mismatch;
    logic [7:0]        err_count;
    logic [$clog2(DEPTH):0] fifo_count;

    aes_loopback_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mode(mode), .keyin(keyin),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_start(core_start), .core_sel(core_sel), .core_key(core_key), .core_data(core_data),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mismatch(mismatch), .err_count(err_count), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q [$];

    int  core_lat     = 1;
    bit  core_en      = 1'b1;
    bit  core_corrupt = 1'b0;
    bit  inject       = 1'b0;
    bit  rand_ready   = 1'b0;
    int  start_cnt    = 0;
    int  sel1_cnt     = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Ideal cipher is x ^ key, so a clean loopback returns the plaintext
    function automatic logic [DATA_W-1:0] model(input logic [1:0] m, input logic [DATA_W-1:0] k,
                                               input logic [DATA_W-1:0] d, input bit corrupt);
        if (m[1] == 1'b0) return d ^ k;
        return corrupt ? (d ^ {{(DATA_W-1){1'b0}}, 1'b1}) : d;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: result appears core_lat cycles after the edge that samples core_start
    initial begin
        int cnt;
        logic [DATA_W-1:0] pend;
        cnt = 0;
        pend = '0;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_result = pend;
                end
            end
            if (inject) begin
                core_done = 1'b1;
                core_result = rnd_blk();
                inject = 1'b0;
            end
            if (rst && core_start) begin
                start_cnt++;
                if (core_sel) sel1_cnt++;
                if (core_en) begin
                    cnt = core_lat + 1;
                    pend = core_data ^ core_key;
                    if (core_sel && core_corrupt) pend[0] = ~pend[0];
                end
            end
        end
    end

    // Output monitor: ordering, one transfer per handshake, stability under backpressure
    initial begin
        bit stall;
        logic [DATA_W-1:0] prev;
        stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            if (rst && out_valid) begin
                if (stall) check("out_stable", out_data, prev);
                if (out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_out", out_data, '0);
                    else check("out_data", out_data, exp_q.pop_front());
                end
                stall = !out_ready;
                prev = out_data;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic push_blk(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e, input bit want);
        int t;
        in_data = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (want) exp_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b1;
        #1 check("in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_edge", in_ready, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] k;
        int s0;
        int t;
        rst = 1'b0;
        mode = 2'b00;
        keyin = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        do_reset();

        // Loopback known vector
        mode = 2'b10;
        keyin = rnd_blk();
        d = 128'h00112233445566778899AABBCCDDEEFF;
        push_blk(d, d, 1'b1);
        drain();
        check("loop_mismatch", mismatch, 0);
        check("loop_err", err_count, 0);

        // Push-to-out_valid latency, single and loopback
        mode = 2'b00;
        core_lat = 1;
        d = rnd_blk();
        push_blk(d, model(mode, keyin, d, 1'b0), 1'b1);
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        check("lat_single", t, 3 + 1);
        drain();
        mode = 2'b10;
        core_lat = 2;
        d = rnd_blk();
        push_blk(d, d, 1'b1);
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        check("lat_loop", t, 5 + 2 + 2);
        drain();

        // Encrypt-only vector with start pulse accounting
        core_lat = 1;
        start_cnt = 0;
        sel1_cnt = 0;
        mode = 2'b00;
        keyin = {16{8'h0F}};
        push_blk({16{8'hF0}}, {16{8'hFF}}, 1'b1);
        drain();
        check("enc_starts", start_cnt, 1);
        check("enc_sel1", sel1_cnt, 0);

        // Backpressure: DEPTH+1 blocks, mode 11 behaves as loopback
        out_ready = 1'b0;
        mode = 2'b11;
        keyin = rnd_blk();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = rnd_blk();
            push_blk(d, d, 1'b1);
        end
        repeat (20) @(posedge clk);
        #1;
        check("full_count", fifo_count, DEPTH);
        check("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        drain();

        // Mode/key change while a block is in flight
        mode = 2'b00;
        k = rnd_blk();
        keyin = k;
        s0 = start_cnt;
        d = rnd_blk();
        push_blk(d, d ^ k, 1'b1);
        t = 0;
        while (start_cnt == s0 && t < 100) begin @(posedge clk); #1; t++; end
        check("inflight_start_seen", start_cnt != s0, 1);
        mode = 2'b01;
        keyin = ~k;
        drain();

        // Stray core_done while idle
        @(posedge clk); #1 inject = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stray_err", err_count, 0);
        check("stray_fifo", fifo_count, 0);
        check("stray_out_valid", out_valid, 0);

        // Corrupted decryption in loopback
        core_corrupt = 1'b1;
        mode = 2'b10;
        keyin = rnd_blk();
        for (int i = 0; i < 3; i++) begin
            d = rnd_blk();
            push_blk(d, model(mode, keyin, d, 1'b1), 1'b1);
        end
        drain();
        check("corrupt_mismatch", mismatch, 1);
        check("corrupt_err", err_count, 3);
        core_corrupt = 1'b0;

        // Core never answers
        do_reset();
        core_en = 1'b0;
        mode = 2'b00;
        s0 = start_cnt;
        push_blk(rnd_blk(), '0, 1'b0);
        t = 0;
        while (start_cnt == s0 && t < 100) begin @(posedge clk); #1; t++; end
        t = 0;
        while (err_count == 0 && t < 500) begin @(posedge clk); #1; t++; end
        check("timeout_cycles", t, TIMEOUT);
        repeat (5) @(posedge clk);
        #1;
        check("timeout_err", err_count, 1);
        check("timeout_out_valid", out_valid, 0);
        check("timeout_fifo", fifo_count, 0);
        core_en = 1'b1;

        // Reset during WAIT2 with two blocks queued
        mode = 2'b10;
        core_lat = 6;
        keyin = rnd_blk();
        s0 = start_cnt;
        for (int i = 0; i < 3; i++) push_blk(rnd_blk(), '0, 1'b0);
        t = 0;
        while (start_cnt < s0 + 2 && t < 200) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        check("pre_rst_fifo", fifo_count, 2);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_fifo", fifo_count, 0);
        check("mid_rst_out_valid", out_valid, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        core_lat = 1;
        d = rnd_blk();
        push_blk(d, d, 1'b1);
        drain();
        check("post_rst_err", err_count, 0);
        check("post_rst_mismatch", mismatch, 0);

        // Randomized batches with random backpressure
        rand_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            mode = 2'($urandom_range(0, 3));
            keyin = rnd_blk();
            core_lat = $urandom_range(1, 4);
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
                d = rnd_blk();
                push_blk(d, model(mode, keyin, d, 1'b0), 1'b1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            drain();
        end
        rand_ready = 1'b0;
        #1 out_ready = 1'b1;
        check("rand_err", err_count, 0);
        check("rand_mismatch", mismatch, 0);
        check("rand_fifo", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
